ejector_sink: RTL and testbench
===============================

// Module: ejector_sink
// PURPOSE
//  Traffic sink at a router Local output port; the receive end of the injector Req/Gnt/Full link.
//  Accepts 32-bit packets {xDst[31:28],yDst[27:24],xSrc[23:20],ySrc[19:16],PacketID[15:6],ModuleID[5:0]}
//  into a small FIFO and drains them to the local PE at a fixed rate.
//  Counts received packets and misrouted packets (destination != this router) for NoC statistics.
// PARAMETERS
//  routerID      6'b000_000  {x[5:3],y[2:0]} position of this router; compared to xDst[2:0],yDst[2:0]
//  dataWidth     32          packet width; fixed at 32 by the field map above
//  FIFO_DEPTH    4           receive buffer entries; power of 2, range 2..16
//  DRAIN_PERIOD  1           cycles between PE pops; range 1..255
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous reset, active-high
//  ReqUpStr     in   1   router requests transfer; PacketIn stays stable while high
//  GntUpStr     out  1   one-cycle grant; packet captured on the same edge that raises it
//  UpStrFull    out  1   high when FIFO holds FIFO_DEPTH entries
//  PacketIn     in   32  packet from router Local output
//  PacketOut    out  32  packet popped to PE, valid with ValidOut
//  ValidOut     out  1   one-cycle pulse per popped packet
//  PktCount     out  32  packets accepted since reset (wraps at 2^32)
//  DstErrCount  out  16  accepted packets with dst position != routerID (saturates at 16'hFFFF)
//  SeqErrCount  out  16  PacketID sequence errors (see CONFIGURATION); saturates
// BEHAVIOUR
//  Reset (sync, dominates everything): GntUpStr=0, ValidOut=0, PacketOut=0, FIFO emptied, UpStrFull=0,
//   all counters 0, FSM=IDLE. Reset mid-handshake drops the grant; the in-flight packet is lost.
//  Handshake FSM (2-bit):
//   IDLE:    ReqUpStr && !UpStrFull -> push PacketIn, GntUpStr<=1, PktCount++, -> GRANT.
//            ReqUpStr && UpStrFull  -> stay, no grant (Req held until space frees).
//   GRANT:   GntUpStr<=0 -> RELEASE.
//   RELEASE: stay while ReqUpStr=1 (sender drops Req one cycle after seeing Gnt); ReqUpStr=0 -> IDLE.
//   Never captures one Req twice; max acceptance 1 packet per 3 cycles.
//  Full decision uses registered occupancy of current cycle; a same-cycle pop does not enable a push.
//  Destination check at push: {xDst[2:0],yDst[2:0]} != routerID -> DstErrCount++ (direction bits ignored).
//  Drain: free-running period counter 0..DRAIN_PERIOD-1; at terminal count with FIFO non-empty,
//   pop head -> PacketOut, ValidOut=1 next cycle. Empty at terminal count: no pop, counter still wraps.
//  Simultaneous push and pop: occupancy unchanged, ordering FIFO, pointers wrap mod FIFO_DEPTH.
//  UpStrFull registered from occupancy; deasserts the cycle after a pop from full.
//  PacketOut holds last popped value when ValidOut=0.
// CONFIGURATION
//  EJECTOR_SEQ_CHECK_EN defined: 64x10-bit expected-ID table indexed by ModuleID, all reset to 1.
//   At push, PacketID != exp[ModuleID] -> SeqErrCount++; always exp[ModuleID] <= PacketID+1 (mod 1024, resync).
//  Undefined: no table, SeqErrCount tied to 0.
// TESTING
//  1 routerID=6'b010_010, send 0xA2000041 (dst 010/010, ID=1, Mod=1) -> Gnt 1 cycle after Req, PktCount=1,
//    DstErrCount=0, ValidOut with PacketOut=0xA2000041 within DRAIN_PERIOD+1 cycles.
//  2 Packet with xDst=4'b0_011 -> accepted and granted, DstErrCount=1.
//  3 DRAIN_PERIOD=255, 5 back-to-back Reqs, depth 4 -> 4 grants, UpStrFull=1, 5th Req waits ungranted
//    until first pop, then granted; output order equals input order.
//  4 Req held high 4 cycles after Gnt -> exactly one push, PktCount increments by 1.
//  5 Assert reset in GRANT with 2 entries queued -> next cycle Gnt=0, UpStrFull=0, counters 0, no ValidOut.
//  6 SEQ_CHECK_EN: ModuleID 5 IDs 1,2,4,5 -> SeqErrCount=1; undefined build -> SeqErrCount stays 0.

Source files
------------

// File: rtl/ejector_sink.sv
`default_nettype none
// ============================================================================
// Module   : ejector_sink
// Purpose  : Traffic sink on a router Local output port. It is the receive end
//            of the Req/Gnt/Full injector link. Accepted packets go into a
//            small FIFO and are drained to the local PE at a fixed rate.
//            Received and misrouted packets are counted for NoC statistics.
//            Optional PacketID sequence checking is built in when
//            EJECTOR_SEQ_CHECK_EN is defined.
// Ports    : clk          rising-edge clock
//            reset        synchronous reset, active-high
//            ReqUpStr     router transfer request (PacketIn stable while high)
//            GntUpStr     one-cycle grant, raised by the edge that captures
//            UpStrFull    FIFO holds FIFO_DEPTH entries
//            PacketIn     32-bit packet from the router Local output
//            PacketOut    packet popped to the PE, valid with ValidOut
//            ValidOut     one-cycle pulse per popped packet
//            PktCount     packets accepted since reset (wrapping)
//            DstErrCount  accepted packets not addressed here (saturating)
//            SeqErrCount  PacketID sequence errors (saturating, 0 if disabled)
// Packet   : {xDst[31:28], yDst[27:24], xSrc[23:20], ySrc[19:16],
//             PacketID[15:6], ModuleID[5:0]}
// Revision : 1.0 - initial release
// ============================================================================
module ejector_sink #(
    parameter logic [5:0] ROUTER_ID    = 6'b000_000,
    parameter int         DATA_WIDTH   = 32,
    parameter int         FIFO_DEPTH   = 4,
    parameter int         DRAIN_PERIOD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReqUpStr,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    output logic [DATA_WIDTH-1:0] PacketOut,
    output logic                  ValidOut,
    output logic [31:0]           PktCount,
    output logic [15:0]           DstErrCount,
    output logic [15:0]           SeqErrCount
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_GRANT   = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_nextState;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_termCnt;
    logic                  w_dstErr;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wrPtr;
    logic [c_PTR_W-1:0]    r_rdPtr;
    logic [c_CNT_W-1:0]    r_count;
    logic [7:0]            r_divCnt;
    logic [DATA_WIDTH-1:0] r_pktOut;
    logic                  r_validOut;
    logic [31:0]           r_pktCount;
    logic [15:0]           r_dstErrCount;

    // Full is taken from the occupancy registered this cycle, so a pop on
    // the same edge never makes room for a push on that edge.
    assign UpStrFull   = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign GntUpStr    = (r_state == c_ST_GRANT);
    assign PacketOut   = r_pktOut;
    assign ValidOut    = r_validOut;
    assign PktCount    = r_pktCount;
    assign DstErrCount = r_dstErrCount;

    assign w_termCnt = (r_divCnt == 8'(DRAIN_PERIOD - 1));
    assign w_pop     = w_termCnt && (r_count != '0);
    // Only the low three position bits of each destination field are
    // compared; the top bit of xDst/yDst is a direction flag.
    assign w_dstErr  = ({PacketIn[30:28], PacketIn[26:24]} != ROUTER_ID);

    // Handshake: capture in IDLE, grant for one cycle, then wait for the
    // sender to drop Req so that one request is never captured twice.
    always_comb begin
        w_nextState = r_state;
        w_push      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (ReqUpStr && !UpStrFull) begin
                    w_push      = 1'b1;
                    w_nextState = c_ST_GRANT;
                end
            end
            c_ST_GRANT:   w_nextState = c_ST_RELEASE;
            c_ST_RELEASE: begin
                if (!ReqUpStr) begin
                    w_nextState = c_ST_IDLE;
                end
            end
            default:      w_nextState = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Storage array carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= PacketIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_divCnt      <= '0;
            r_pktOut      <= '0;
            r_validOut    <= 1'b0;
            r_pktCount    <= '0;
            r_dstErrCount <= '0;
        end else begin
            r_divCnt   <= w_termCnt ? 8'd0 : r_divCnt + 8'd1;
            r_validOut <= w_pop;

            if (w_push) begin
                r_wrPtr    <= r_wrPtr + c_PTR_W'(1);
                r_pktCount <= r_pktCount + 32'd1;
                if (w_dstErr && (r_dstErrCount != 16'hFFFF)) begin
                    r_dstErrCount <= r_dstErrCount + 16'd1;
                end
            end

            if (w_pop) begin
                r_pktOut <= r_mem[r_rdPtr];
                r_rdPtr  <= r_rdPtr + c_PTR_W'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

`ifdef EJECTOR_SEQ_CHECK_EN
    logic [9:0]  r_expId [64];
    logic [15:0] r_seqErrCount;
    logic [5:0]  w_modId;
    logic [9:0]  w_pktId;

    assign w_modId     = PacketIn[5:0];
    assign w_pktId     = PacketIn[15:6];
    assign SeqErrCount = r_seqErrCount;

    // Expected ID always resyncs to the received ID + 1, so one gap in the
    // sequence is reported once rather than on every later packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                r_expId[i] <= 10'd1;
            end
            r_seqErrCount <= '0;
        end else if (w_push) begin
            if ((w_pktId != r_expId[w_modId]) && (r_seqErrCount != 16'hFFFF)) begin
                r_seqErrCount <= r_seqErrCount + 16'd1;
            end
            r_expId[w_modId] <= w_pktId + 10'd1;
        end
    end
`else
    assign SeqErrCount = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ejector_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_ejector_sink
// Purpose  : Directed self-checking bench for ejector_sink
//            (ROUTER_ID 010_010, FIFO_DEPTH 4, DRAIN_PERIOD 255).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ejector_sink;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        ReqUpStr = 1'b0;
    logic [31:0] PacketIn = 32'd0;
    logic        GntUpStr;
    logic        UpStrFull;
    logic [31:0] PacketOut;
    logic        ValidOut;
    logic [31:0] PktCount;
    logic [15:0] DstErrCount;
    logic [15:0] SeqErrCount;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [31:0] outQ[$];
    int          validCyc[$];

    ejector_sink #(
        .ROUTER_ID   (6'b010_010),
        .DATA_WIDTH  (32),
        .FIFO_DEPTH  (4),
        .DRAIN_PERIOD(255)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .ReqUpStr   (ReqUpStr),
        .GntUpStr   (GntUpStr),
        .UpStrFull  (UpStrFull),
        .PacketIn   (PacketIn),
        .PacketOut  (PacketOut),
        .ValidOut   (ValidOut),
        .PktCount   (PktCount),
        .DstErrCount(DstErrCount),
        .SeqErrCount(SeqErrCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle = cycle + 1;

    always @(negedge clk) begin
        if (ValidOut) begin
            outQ.push_back(PacketOut);
            validCyc.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] qAt(input int i);
        logic [31:0] v;
        v = 32'hxxxxxxxx;
        if (i < outQ.size()) v = outQ[i];
        return v;
    endfunction

    task automatic doReset();
        reset    = 1'b1;
        ReqUpStr = 1'b0;
        step();
        step();
        outQ.delete();
        validCyc.delete();
        reset = 1'b0;
    endtask

    // Raise Req, wait for Gnt (bounded), drop Req and let the FSM return to
    // IDLE. waited = cycles until Gnt seen, or -1 on timeout.
    task automatic send(input logic [31:0] pkt, input int maxWait,
                        output int waited, output int gntCyc);
        ReqUpStr = 1'b1;
        PacketIn = pkt;
        waited   = 0;
        gntCyc   = -1;
        do begin
            step();
            waited++;
        end while (!GntUpStr && waited < maxWait);
        if (GntUpStr) gntCyc = cycle;
        else          waited = -1;
        ReqUpStr = 1'b0;
        step();
        step();
    endtask

    logic [31:0] pk [5];
    logic [31:0] sq [4];
    int w, g, gnts;

    initial begin
        pk[0] = 32'h22000042; pk[1] = 32'h22000082; pk[2] = 32'h220000C2;
        pk[3] = 32'h22000102; pk[4] = 32'h22000142;
        sq[0] = 32'h22000045; sq[1] = 32'h22000085;
        sq[2] = 32'h22000105; sq[3] = 32'h22000145;

        step();
        doReset();

        // Reset state
        check("rst_gnt",    32'(GntUpStr),    32'd0);
        check("rst_full",   32'(UpStrFull),   32'd0);
        check("rst_valid",  32'(ValidOut),    32'd0);
        check("rst_pktout", PacketOut,        32'd0);
        check("rst_pktcnt", PktCount,         32'd0);
        check("rst_dsterr", 32'(DstErrCount), 32'd0);
        check("rst_seqerr", 32'(SeqErrCount), 32'd0);

        // Basic transfer to this router, then drain
        send(32'hA2000041, 4, w, g);
        check("t1_gnt_latency", 32'(w),           32'd1);
        check("t1_pktcnt",      PktCount,         32'd1);
        check("t1_dsterr",      32'(DstErrCount), 32'd0);
        for (int i = 0; i < 260 && outQ.size() < 1; i++) step();
        check("t1_valid_seen",  32'(outQ.size()), 32'd1);
        check("t1_pktout",      qAt(0),           32'hA2000041);
        step();
        check("t1_valid_pulse", 32'(ValidOut),    32'd0);
        check("t1_pktout_hold", PacketOut,        32'hA2000041);

        // Misrouted packet, then a packet whose direction bits differ only
        send(32'h32000081, 4, w, g);
        check("t2_gnt_latency", 32'(w),           32'd1);
        check("t2_dsterr",      32'(DstErrCount), 32'd1);
        check("t2_pktcnt",      PktCount,         32'd2);
        send(32'hAA0000C1, 4, w, g);
        check("t2_dir_ignored", 32'(DstErrCount), 32'd1);
        check("t2_pktcnt2",     PktCount,         32'd3);

        // Fill to depth, fifth request waits for the first pop
        doReset();
        gnts = 0;
        for (int i = 0; i < 4; i++) begin
            send(pk[i], 4, w, g);
            if (w == 1) gnts++;
        end
        check("t3_four_grants", 32'(gnts),      32'd4);
        check("t3_full",        32'(UpStrFull), 32'd1);
        send(pk[4], 300, w, g);
        check("t3_fifth_waited", 32'(w > 1),    32'd1);
        check("t3_fifth_after_pop", 32'(g),
              32'((validCyc.size() > 0) ? validCyc[0] + 1 : -99));
        for (int i = 0; i < 1100 && outQ.size() < 5; i++) step();
        check("t3_out_count", 32'(outQ.size()), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_order%0d", i), qAt(i), pk[i]);

        // Req held well past Gnt yields one capture
        doReset();
        ReqUpStr = 1'b1;
        PacketIn = pk[0];
        gnts = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (GntUpStr) gnts++;
        end
        ReqUpStr = 1'b0;
        step();
        step();
        check("t4_one_grant", 32'(gnts), 32'd1);
        check("t4_pktcnt",    PktCount,  32'd1);

        // Reset while in GRANT with two entries queued
        doReset();
        send(pk[0], 4, w, g);
        ReqUpStr = 1'b1;
        PacketIn = pk[1];
        step();
        check("t5_in_grant", 32'(GntUpStr), 32'd1);
        reset    = 1'b1;
        ReqUpStr = 1'b0;
        step();
        check("t5_gnt",    32'(GntUpStr),    32'd0);
        check("t5_full",   32'(UpStrFull),   32'd0);
        check("t5_pktcnt", PktCount,         32'd0);
        check("t5_dsterr", 32'(DstErrCount), 32'd0);
        check("t5_valid",  32'(ValidOut),    32'd0);
        reset = 1'b0;
        outQ.delete();
        validCyc.delete();
        for (int i = 0; i < 300; i++) step();
        check("t5_no_output", 32'(outQ.size()), 32'd0);
        send(pk[2], 4, w, g);
        check("t5_idle_after", 32'(w),  32'd1);
        check("t5_pktcnt_new", PktCount, 32'd1);

        // PacketID sequence check on ModuleID 5: IDs 1,2,4,5
        doReset();
        for (int i = 0; i < 4; i++) send(sq[i], 4, w, g);
        check("t6_pktcnt", PktCount, 32'd4);
`ifdef EJECTOR_SEQ_CHECK_EN
        check("t6_seqerr", 32'(SeqErrCount), 32'd1);
`else
        check("t6_seqerr", 32'(SeqErrCount), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
